filter_sequencer: RTL and testbench

Parametrised controller that steps the edge-detector datapath through its combinational filter blocks each time the pixel anchor moves. It supports two filter types: a single-pass smoothing filter, and a two-pass gradient filter (X pass, then Y pass). Each type has a configurable block count. Block advance is gated by a ready/valid handshake with the datapath. The block also supports abort, restart on a new anchor move, and back-to-back runs. It sits between the anchor/window logic and the filter datapath, and replaces the fixed-length filter controller.

---
 rtl/filter_sequencer_if.sv | 36 +++
 rtl/filter_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_filter_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_sequencer_if.sv
// ---------------------------------------------------------------------------
// filter_sequencer_if
//   Block handshake between the filter sequencer and the filter datapath.
//
//   Signals:
//     block        block ID the datapath should apply
//     block_valid  block is meaningful and awaiting acceptance
//     pass         gradient pass (0 = X, 1 = Y), 0 for smoothing
//     block_ready  datapath accepts the current block this cycle
//
//   Modports:
//     master  sequencer side (drives block/block_valid/pass)
//     slave   datapath side (drives block_ready)
// ---------------------------------------------------------------------------
interface filter_sequencer_if #(
    parameter int BLOCK_W = 4
);
    logic [BLOCK_W-1:0] block;
    logic               block_valid;
    logic               pass;
    logic               block_ready;

    modport master (
        output block,
        output block_valid,
        output pass,
        input  block_ready
    );

    modport slave (
        input  block,
        input  block_valid,
        input  pass,
        output block_ready
    );
endinterface

// File: rtl/filter_sequencer.sv
// ---------------------------------------------------------------------------
// filter_sequencer
//   Steps the edge-detector datapath through its filter blocks each time the
//   pixel anchor moves. Type 0 is a single smoothing pass of SMOOTH_LEN
//   blocks; type 1 is a gradient filter made of an X pass and a Y pass of
//   GRAD_LEN blocks each. Blocks advance on a valid/ready handshake.
//
//   Ports:
//     clk            system clock, rising edge
//     n_rst          asynchronous active-low reset
//     anchor_moving  start / restart request (level sampled)
//     filter_type    filter type sampled with anchor_moving (0 smooth, 1 grad)
//     abort          synchronous abort of the current run
//     blk_if         block handshake (block, block_valid, pass, block_ready)
//     busy           high while a run is in progress
//     filter_done    one-cycle pulse when a run completes
//
//   Block IDs: smoothing uses 0..SMOOTH_LEN-1; gradient uses
//   SMOOTH_LEN + pass*GRAD_LEN + idx.
// ---------------------------------------------------------------------------
module filter_sequencer #(
    parameter int BLOCK_W         = 4,
    parameter int SMOOTH_LEN      = 5,
    parameter int GRAD_LEN        = 3,
    parameter int RESTART_ON_MOVE = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                anchor_moving,
    input  logic                filter_type,
    input  logic                abort,
    filter_sequencer_if.master  blk_if,
    output logic                busy,
    output logic                filter_done
);

    // Reject configurations whose block IDs would not fit in BLOCK_W bits.
    if (SMOOTH_LEN < 1 || GRAD_LEN < 1 ||
        (SMOOTH_LEN + 2 * GRAD_LEN) > (1 << BLOCK_W)) begin : g_illegal_params
        $error("filter_sequencer: illegal SMOOTH_LEN/GRAD_LEN/BLOCK_W combination");
    end

    localparam logic [BLOCK_W-1:0] SMOOTH_LAST = BLOCK_W'(SMOOTH_LEN - 1);
    localparam logic [BLOCK_W-1:0] GRAD_LAST   = BLOCK_W'(GRAD_LEN - 1);
    localparam logic [BLOCK_W-1:0] GRAD_BASE   = BLOCK_W'(SMOOTH_LEN);
    localparam logic [BLOCK_W-1:0] GRAD_STEP   = BLOCK_W'(GRAD_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROCESSING,
        ST_DONE
    } state_t;

    // Control state
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_type;
    logic               w_type_nxt;
    logic [BLOCK_W-1:0] r_idx;
    logic [BLOCK_W-1:0] w_idx_nxt;
    logic               r_pass;
    logic               w_pass_nxt;

    // Output registers
    logic [BLOCK_W-1:0] r_block;
    logic [BLOCK_W-1:0] w_block_nxt;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_last;

    // Last block of the current pass, judged on the latched type.
    assign w_last = (r_idx == (r_type ? GRAD_LAST : SMOOTH_LAST));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_type  <= 1'b0;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_block <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_type  <= w_type_nxt;
            r_idx   <= w_idx_nxt;
            r_pass  <= w_pass_nxt;
            r_block <= w_block_nxt;
            r_valid <= (w_state_nxt == ST_PROCESSING);
            r_busy  <= (w_state_nxt == ST_PROCESSING);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Next-state logic. Priority inside PROCESSING: abort > restart > advance.
    // idx/pass are cleared whenever PROCESSING is left so that IDLE and DONE
    // present block 0 / pass 0 without extra gating.
    always_comb begin
        w_state_nxt = r_state;
        w_type_nxt  = r_type;
        w_idx_nxt   = r_idx;
        w_pass_nxt  = r_pass;

        unique case (r_state)
            ST_IDLE: begin
                if (!abort && anchor_moving) begin
                    w_state_nxt = ST_PROCESSING;
                    w_type_nxt  = filter_type;
                    w_idx_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                end
            end

            ST_PROCESSING: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                end else if ((RESTART_ON_MOVE != 0) && anchor_moving) begin
                    // Restart discards any transfer happening this cycle.
                    w_state_nxt = ST_PROCESSING;
                    w_type_nxt  = filter_type;
                    w_idx_nxt   = '0;
                    w_pass_nxt  = 1'b0;
                end else if (blk_if.block_ready) begin
                    if (w_last) begin
                        if (r_type && !r_pass) begin
                            w_pass_nxt = 1'b1;
                            w_idx_nxt  = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                            w_idx_nxt   = '0;
                            w_pass_nxt  = 1'b0;
                        end
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (!abort && anchor_moving) begin
                    // Back-to-back run: no IDLE gap.
                    w_state_nxt = ST_PROCESSING;
                    w_type_nxt  = filter_type;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                w_idx_nxt  = '0;
                w_pass_nxt = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
                w_pass_nxt  = 1'b0;
            end
        endcase
    end

    // Block ID for the coming cycle, encoded from the next-state values so
    // that the registered output lines up with the registered valid.
    always_comb begin
        w_block_nxt = '0;
        if (w_state_nxt == ST_PROCESSING) begin
            if (w_type_nxt) begin
                w_block_nxt = GRAD_BASE + (w_pass_nxt ? GRAD_STEP : '0) + w_idx_nxt;
            end else begin
                w_block_nxt = w_idx_nxt;
            end
        end
    end

    assign blk_if.block       = r_block;
    assign blk_if.block_valid = r_valid;
    assign blk_if.pass        = r_pass;
    assign busy               = r_busy;
    assign filter_done        = r_done;

endmodule

// File: tb/tb_filter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_filter_sequencer
//   Directed self-checking bench for filter_sequencer with default sizing
//   (smoothing blocks 0..4, gradient X 5..7, gradient Y 8..10).
// ---------------------------------------------------------------------------
module tb_filter_sequencer;

    localparam int SL = 5;
    localparam int GL = 3;

    logic clk           = 1'b0;
    logic n_rst         = 1'b0;
    logic anchor_moving = 1'b0;
    logic filter_type   = 1'b0;
    logic abort         = 1'b0;
    logic busy;
    logic filter_done;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    filter_sequencer_if #(.BLOCK_W(4)) u_if ();

    filter_sequencer #(
        .BLOCK_W        (4),
        .SMOOTH_LEN     (SL),
        .GRAD_LEN       (GL),
        .RESTART_ON_MOVE(1)
    ) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .anchor_moving(anchor_moving),
        .filter_type  (filter_type),
        .abort        (abort),
        .blk_if       (u_if.master),
        .busy         (busy),
        .filter_done  (filter_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(u_if.block_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),             32'd0);
        check({tag, "_done"},  32'(filter_done),      32'd0);
        check({tag, "_block"}, 32'(u_if.block),       32'd0);
        check({tag, "_pass"},  32'(u_if.pass),        32'd0);
    endtask

    task automatic check_active(input string tag, input int blk, input int p);
        check({tag, "_block"}, 32'(u_if.block),       32'(blk));
        check({tag, "_pass"},  32'(u_if.pass),        32'(p));
        check({tag, "_valid"}, 32'(u_if.block_valid), 32'd1);
        check({tag, "_busy"},  32'(busy),             32'd1);
        check({tag, "_done"},  32'(filter_done),      32'd0);
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},  32'(filter_done),      32'd1);
        check({tag, "_valid"}, 32'(u_if.block_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),             32'd0);
        check({tag, "_block"}, 32'(u_if.block),       32'd0);
    endtask

    // Full run with block_ready held high; starts and ends in IDLE.
    task automatic run_full(input string tag, input logic t);
        filter_type        = t;
        anchor_moving      = 1'b1;
        u_if.block_ready   = 1'b1;
        tick();
        anchor_moving = 1'b0;
        if (!t) begin
            for (int i = 0; i < SL; i++) begin
                check_active({tag, "_sm"}, i, 0);
                tick();
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < GL; i++) begin
                    check_active({tag, "_gr"}, SL + p * GL + i, p);
                    tick();
                end
            end
        end
        check_done({tag, "_end"});
        tick();
        check_idle({tag, "_idle"});
    endtask

    initial begin
        int  exp_idx;
        logic seen_done;

        u_if.block_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check_idle("post_reset");

        // Plain smoothing and gradient runs
        run_full("smooth", 1'b0);
        run_full("grad", 1'b1);

        // Stall: ready pattern 1,0,0,1,0,0,...
        filter_type   = 1'b0;
        anchor_moving = 1'b1;
        tick();
        anchor_moving = 1'b0;
        exp_idx   = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (filter_done) begin
                seen_done = 1'b1;
                break;
            end
            check("stall_block", 32'(u_if.block), 32'(exp_idx));
            check("stall_valid", 32'(u_if.block_valid), 32'd1);
            u_if.block_ready = (c % 3 == 0);
            if (u_if.block_ready) exp_idx++;
            tick();
        end
        check("stall_done_seen", 32'(seen_done), 32'd1);
        check("stall_xfers", 32'(exp_idx), 32'(SL));
        u_if.block_ready = 1'b1;
        tick();
        check_idle("stall_idle");

        // Restart at block 7 of a gradient run with new type 0
        filter_type   = 1'b1;
        anchor_moving = 1'b1;
        tick();
        anchor_moving = 1'b0;
        check_active("rst_b5", 5, 0);
        tick();
        check_active("rst_b6", 6, 0);
        tick();
        check_active("rst_b7", 7, 0);
        anchor_moving = 1'b1;
        filter_type   = 1'b0;
        tick();
        anchor_moving = 1'b0;
        filter_type   = 1'b1;   // must be ignored mid-run
        for (int i = 0; i < SL; i++) begin
            check_active("rst_sm", i, 0);
            tick();
        end
        check_done("rst_end");
        tick();
        check_idle("rst_idle");
        filter_type = 1'b0;

        // Abort at block 3
        anchor_moving = 1'b1;
        tick();
        anchor_moving = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_active("abort_run", i, 0);
            if (i < 3) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_next");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", 32'(filter_done), 32'd0);
        end
        run_full("after_abort", 1'b0);

        // abort together with anchor_moving in IDLE stays IDLE
        abort         = 1'b1;
        anchor_moving = 1'b1;
        tick();
        abort         = 1'b0;
        anchor_moving = 1'b0;
        check_idle("abort_start");

        // Back-to-back: anchor_moving asserted only in the DONE cycle
        filter_type   = 1'b0;
        anchor_moving = 1'b1;
        tick();
        anchor_moving = 1'b0;
        for (int i = 0; i < SL; i++) begin
            check_active("b2b_sm", i, 0);
            tick();
        end
        check_done("b2b_done");
        anchor_moving = 1'b1;
        filter_type   = 1'b1;
        tick();
        anchor_moving = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < GL; i++) begin
                check_active("b2b_gr", SL + p * GL + i, p);
                tick();
            end
        end
        check_done("b2b_end");
        tick();
        check_idle("b2b_idle");

        // Asynchronous reset mid-run
        filter_type   = 1'b1;
        anchor_moving = 1'b1;
        tick();
        anchor_moving = 1'b0;
        tick();
        check_active("arst_pre", 6, 0);
        #2;
        n_rst = 1'b0;
        #1;
        check_idle("arst_now");
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        check_idle("arst_after");
        run_full("arst_rerun", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
